// File: rtl/bus_defs.sv
// Shared definitions for the maxicore32 bus target: bus widths, I/O register
// offsets and the byte-strobe legality check.
package bus_defs;

  localparam int ADDR_W = 30;  // word address width, byte address [31:2]
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IO_LED     = 2'd0,
    IO_CYCLE   = 2'd1,
    IO_ERRCNT  = 2'd2,
    IO_LASTERR = 2'd3
  } io_reg_e;

  // Naturally aligned byte, half-word or full word lanes only.
  function automatic logic strobe_valid(input logic [STRB_W-1:0] strb);
    case (strb)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Byte-strobed RAM with asynchronous read; unselected lanes keep the old
// contents by merging them back from the read port before the word write.
module bus_ram
  import bus_defs::*;
#(
  parameter int RAM_ADDR_WIDTH = 10
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [RAM_ADDR_WIDTH-1:0] addr,
  input  logic [STRB_W-1:0]         strb,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [DATA_W-1:0] merged;

  assign rdata = mem[addr];

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign merged[8*gi +: 8] = strb[gi] ? wdata[8*gi +: 8] : rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= merged;
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Single-cycle memory-mapped target: RAM region plus a four-register I/O bank
// (LED, cycle counter, error counter, last error address).
module bus_responder
  import bus_defs::*;
#(
  parameter int          RAM_ADDR_WIDTH = 10,
  parameter logic [31:0] IO_BASE        = 32'hFFFF0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic [STRB_W-1:0] data_strobes,
  input  logic              read,
  input  logic              write,
  output logic              bus_error,
  output logic [DATA_W-1:0] led
);

  logic [DATA_W-1:0] led_q, led_d;
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] errcnt_q, errcnt_d;
  logic [DATA_W-1:0] lasterr_q, lasterr_d;

  logic              req;
  logic              ram_hit;
  logic              io_hit;
  logic              strb_ok;
  logic              ro_write;
  logic              err;
  logic              ram_we;
  io_reg_e           io_sel;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] io_rdata;

  assign req     = read | write;
  assign ram_hit = (address[ADDR_W-1:RAM_ADDR_WIDTH] == '0);
  assign io_hit  = (address[ADDR_W-1:2] == IO_BASE[31:4]);
  assign io_sel  = io_reg_e'(address[1:0]);
  assign strb_ok = strobe_valid(data_strobes);

  assign ro_write = io_hit && write && ((io_sel == IO_CYCLE) || (io_sel == IO_LASTERR));

  assign err = req && ((read && write) || !(ram_hit || io_hit) || !strb_ok ||
                       (io_hit && (data_strobes != 4'b1111)) || ro_write);

  assign ram_we = write && ram_hit && !err;

  bus_ram #(
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (address[RAM_ADDR_WIDTH-1:0]),
    .strb (data_strobes),
    .wdata(data_in),
    .rdata(ram_rdata)
  );

  always_comb begin
    io_rdata = '0;
    case (io_sel)
      IO_LED:     io_rdata = led_q;
      IO_CYCLE:   io_rdata = cycle_q;
      IO_ERRCNT:  io_rdata = errcnt_q;
      IO_LASTERR: io_rdata = lasterr_q;
      default:    io_rdata = '0;
    endcase
  end

  always_comb begin
    data_out = '0;
    if (read && !err) begin
      data_out = ram_hit ? ram_rdata : io_rdata;
    end
  end

  assign bus_error = err;
  assign led       = led_q;

  // A clear of the error counter is always a valid write, so it never
  // competes with the saturating increment.
  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + 32'd1;
    errcnt_d  = errcnt_q;
    lasterr_d = lasterr_q;
    if (err) begin
      errcnt_d  = (errcnt_q == '1) ? errcnt_q : errcnt_q + 32'd1;
      lasterr_d = {address, 2'b00};
    end else if (write && io_hit) begin
      if (io_sel == IO_LED)    led_d    = data_in;
      if (io_sel == IO_ERRCNT) errcnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      cycle_q   <= '0;
      errcnt_q  <= '0;
      lasterr_q <= '0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      errcnt_q  <= errcnt_d;
      lasterr_q <= lasterr_d;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: a spec-level model checked every cycle plus
// hand-computed expectations for the listed scenarios.
module tb_bus_responder;

  localparam logic [31:0] IOB = 32'hFFFF0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  data_strobes = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        bus_error;
  logic [31:0] led;

  int total = 0;
  int bad = 0;
  bit started = 0;

  bus_responder dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_strobes(data_strobes),
    .read        (read),
    .write       (write),
    .bus_error   (bus_error),
    .led         (led)
  );

  always #10 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_led, m_cyc, m_errc, m_last;
  bit          p_err, p_ramw, p_led, p_clr;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_strb;

  always @(negedge clock) begin
    if (started) begin
      logic [31:0] ba;
      logic [31:0] off;
      bit in_ram, in_io, sv, e, known;
      logic [31:0] exp_d;
      ba     = {address, 2'b00};
      off    = ba - IOB;
      in_ram = (ba < 32'h0000_1000);
      in_io  = (ba >= IOB) && (off < 16);
      sv     = data_strobes inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
      e = (read || write) && ((read && write) || !(in_ram || in_io) || !sv ||
          (in_io && data_strobes != 4'hF) || (in_io && write && (off == 4 || off == 12)));
      exp_d = 32'h0;
      known = 1;
      if (read && !e) begin
        if (in_ram) begin
          if (m_mem.exists(ba >> 2)) exp_d = m_mem[ba >> 2];
          else known = 0;
        end else begin
          case (off)
            0:       exp_d = m_led;
            4:       exp_d = m_cyc;
            8:       exp_d = m_errc;
            default: exp_d = m_last;
          endcase
        end
      end
      chk("cyc_bus_error", {31'b0, bus_error}, {31'b0, e});
      if (known) chk("cyc_data_out", data_out, exp_d);
      chk("cyc_led", led, m_led);
      p_err  = e;
      p_ramw = write && !e && in_ram;
      p_led  = write && !e && in_io && off == 0;
      p_clr  = write && !e && in_io && off == 8;
      p_addr = ba;
      p_data = data_in;
      p_strb = data_strobes;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_led = 0; m_cyc = 0; m_errc = 0; m_last = 0;
      p_err = 0; p_ramw = 0; p_led = 0; p_clr = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (p_err) begin
        if (m_errc != 32'hFFFF_FFFF) m_errc = m_errc + 1;
        m_last = p_addr;
      end
      if (p_led) m_led = p_data;
      if (p_clr) m_errc = 0;
      if (p_ramw) begin
        int unsigned idx;
        logic [31:0] w;
        idx = p_addr >> 2;
        if (m_mem.exists(idx) || p_strb == 4'hF) begin
          w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (p_strb[b]) w[8*b +: 8] = p_data[8*b +: 8];
          m_mem[idx] = w;
        end
      end
      p_err = 0; p_ramw = 0; p_led = 0; p_clr = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic r, input logic w, input logic [31:0] ba,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] dout, output logic berr);
    read = r; write = w; address = ba[31:2]; data_in = d; data_strobes = s;
    @(negedge clock);
    dout = data_out;
    berr = bus_error;
    $display("acc r=%0d w=%0d addr=%h data=%h strb=%b -> dout=%h berr=%0d",
             r, w, ba, d, s, dout, berr);
    @(posedge clock);
    #1;
    read = 0; write = 0; data_strobes = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, c1, c2;
    logic        e;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    started = 1;

    chk("rst_led", led, 32'h0);
    acc(1, 0, IOB + 32'h8, 0, 4'hF, d, e); chk("rst_errcnt", d, 32'h0);
    acc(0, 0, 32'h0, 0, 4'h0, d, e);       chk("idle_dout", d, 32'h0);
    chk("idle_berr", {31'b0, e}, 32'h0);

    acc(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, d, e); chk("w10_berr", {31'b0, e}, 32'h0);
    acc(0, 1, 32'h10, 32'h000000AA, 4'h1, d, e); chk("w10b_berr", {31'b0, e}, 32'h0);
    acc(1, 0, 32'h10, 0, 4'hF, d, e);            chk("r10", d, 32'hDEADBEAA);

    acc(0, 1, 32'h20, 32'h0, 4'hF, d, e);
    acc(0, 1, 32'h20, 32'h11223344, 4'hC, d, e);
    acc(1, 0, 32'h20, 0, 4'hF, d, e);            chk("r20_half", d, 32'h11220000);

    acc(1, 0, 32'h1000, 0, 4'hF, d, e);          chk("unmap_berr", {31'b0, e}, 32'h1);
    chk("unmap_dout", d, 32'h0);
    acc(1, 0, IOB + 32'h8, 0, 4'hF, d, e);       chk("errcnt1", d, 32'h1);
    acc(1, 0, IOB + 32'hC, 0, 4'hF, d, e);       chk("lasterr", d, 32'h00001000);

    acc(0, 1, 32'h4, 32'h55555555, 4'hF, d, e);
    acc(0, 1, IOB + 32'h8, 32'h1234, 4'hF, d, e);
    acc(0, 1, 32'h4, 32'hAAAAAAAA, 4'h6, d, e);  chk("strb0110_berr", {31'b0, e}, 32'h1);
    acc(1, 1, 32'h4, 32'hAAAAAAAA, 4'hF, d, e);  chk("rdwr_berr", {31'b0, e}, 32'h1);
    acc(1, 0, 32'h4, 0, 4'hF, d, e);             chk("w4_unchanged", d, 32'h55555555);
    acc(1, 0, IOB + 32'h8, 0, 4'hF, d, e);       chk("errcnt2", d, 32'h2);
    acc(0, 1, IOB + 32'h8, 32'hFFFF, 4'hF, d, e);
    acc(1, 0, IOB + 32'h8, 0, 4'hF, d, e);       chk("errcnt_clr", d, 32'h0);
    acc(1, 0, 32'h8, 0, 4'h0, d, e);             chk("strb0000_berr", {31'b0, e}, 32'h1);

    acc(0, 1, IOB, 32'h000000FF, 4'hF, d, e);    chk("led_set", led, 32'h000000FF);
    acc(0, 1, IOB + 32'h4, 32'h0, 4'hF, d, e);   chk("ro_cycle_berr", {31'b0, e}, 32'h1);
    chk("led_keep1", led, 32'h000000FF);
    acc(0, 1, IOB, 32'h12, 4'h1, d, e);          chk("io_strb_berr", {31'b0, e}, 32'h1);
    chk("led_keep2", led, 32'h000000FF);

    acc(1, 0, IOB + 32'h4, 0, 4'hF, c1, e);
    repeat (4) acc(0, 0, 32'h0, 0, 4'h0, d, e);
    acc(1, 0, IOB + 32'h4, 0, 4'hF, c2, e);      chk("cycle_diff", c2 - c1, 32'd5);

    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_led", led, 32'h0);
    read = 1; address = IOB[31:2] + 30'd1; data_strobes = 4'hF;
    #1; chk("arst_cycle", data_out, 32'h0);
    address = IOB[31:2] + 30'd2;
    #1; chk("arst_errcnt", data_out, 32'h0);
    address = IOB[31:2] + 30'd3;
    #1; chk("arst_lasterr", data_out, 32'h0);
    read = 0; data_strobes = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    acc(1, 0, 32'h10, 0, 4'hF, d, e);            chk("ram_survives_rst", d, 32'hDEADBEAA);
    acc(1, 0, IOB, 0, 4'hF, d, e);               chk("led_after_rst", d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
